// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage between the PC and decode.
//
// Issues instruction-memory reads at the current PC. Each returned
// instruction is pushed, together with its PC+4, into a small skid FIFO
// that feeds decode. pc_adv tells the PC to step after an accepted fetch,
// or to load its redirect target on a flush. Once halt is seen, fetch
// stops for good; only reset restarts it.
//
// Ports:
//   CLK         in   1   clock, rising edge
//   RST         in   1   asynchronous active-high reset
//   cpc         in   32  current PC
//   pc_plus     in   32  cpc + 4
//   imemREN     out  1   instruction memory read enable
//   imemaddr    out  32  instruction memory address (always cpc)
//   imemload    in   32  instruction data, valid with ihit
//   ihit        in   1   instruction memory response valid
//   flush       in   1   redirect: discard queued and in-flight work
//   halt        in   1   decode saw HALT at the FIFO head
//   stall       in   1   decode cannot accept this cycle
//   pc_adv      out  1   PC advance/redirect strobe
//   if_valid    out  1   FIFO head holds a valid instruction
//   if_instr    out  32  instruction at FIFO head (0 when empty)
//   if_pc_plus  out  32  PC+4 of FIFO head (0 when empty)
module fetch_unit #(
    parameter int DEPTH = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] cpc,
    input  logic [31:0] pc_plus,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic [31:0] imemload,
    input  logic        ihit,
    input  logic        flush,
    input  logic        halt,
    input  logic        stall,
    output logic        pc_adv,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc_plus
);
    // A one-entry FIFO still needs a 1-bit pointer; it simply never leaves 0.
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {FETCH, HALTED} state_t;

    state_t        state;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [31:0]   instr_q [DEPTH];
    logic [31:0]   pcp_q   [DEPTH];
    logic          fetching;
    logic          enq;
    logic          deq;
    logic          clear;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    // Gating with RST keeps the strobes low for the whole reset pulse, not
    // just after the state registers have cleared.
    assign fetching   = (state == FETCH) & !RST;
    assign imemaddr   = cpc;
    assign imemREN    = fetching & (count < FULL) & !halt;
    assign enq        = imemREN & ihit & !flush;
    assign deq        = fetching & if_valid & !stall & !flush;
    // halt beats flush: a halting decode keeps its queued HALT at the head.
    assign clear      = fetching & flush & !halt;
    assign pc_adv     = enq | (fetching & flush);
    assign if_valid   = (count != '0);
    assign if_instr   = if_valid ? instr_q[head] : '0;
    assign if_pc_plus = if_valid ? pcp_q[head] : '0;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= FETCH;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (state == FETCH && halt)
                state <= HALTED;
            if (clear) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (enq)
                    tail <= nxt(tail);
                if (deq)
                    head <= nxt(head);
                count <= count + CW'(enq) - CW'(deq);
            end
        end
    end

    // Storage needs no reset: entries are only visible while count != 0.
    always_ff @(posedge CLK) begin
        if (enq) begin
            instr_q[tail] <= imemload;
            pcp_q[tail]   <= pc_plus;
        end
    end
endmodule
